imm_extender_pipe: RTL and testbench
====================================

IMM_EXTENDER_PIPE -- requirements
Module: imm_extender_pipe

Interface
REQ-001 Parameter DATA_WIDTH, 32, output word width.
REQ-002 Parameter WIDTH_A, 16, width of immediate field A (I-type).
REQ-003 Parameter WIDTH_B, 21, width of immediate field B (J-type).
REQ-004 Parameter WIDTH_C, 18, width of immediate field C (branch-type).
REQ-005 Parameter SHIFT_AMOUNT, 2, left shift applied in mode 2'b10.
REQ-006 clock  input  1  sole clock, rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 inputA  input  WIDTH_A  immediate field A.
REQ-009 inputB  input  WIDTH_B  immediate field B.
REQ-010 inputC  input  WIDTH_C  immediate field C.
REQ-011 extenderSelection  input  2  field select: 00=A, 01=B, 10=C, 11=illegal.
REQ-012 extenderMode  input  2  00=zero-ext, 01=sign-ext, 10=sign-ext then shift, 11=upper-place.
REQ-013 inValid  input  1  request valid.
REQ-014 inReady  output  1  block can accept a request.
REQ-015 outValid  output  1  extenderOutput holds a result.
REQ-016 outReady  input  1  consumer accepts result.
REQ-017 extenderOutput  output  DATA_WIDTH  extended result (head of buffer).
REQ-018 errorFlag  output  1  sticky illegal-selection flag (see Configuration).

Function
REQ-019 Transfer in SHALL occur on a rising edge with inValid && inReady; transfer out with outValid && outReady.
REQ-020 Result SHALL be computed combinationally from inputs at input transfer and stored in a 2-entry FIFO skid buffer; extenderOutput always shows the oldest entry.
REQ-021 Occupancy states EMPTY(0), ONE(1), FULL(2); inReady SHALL be 1 in EMPTY/ONE, 0 in FULL, derived from registered state only (no combinational path from outReady).
REQ-022 outValid SHALL equal (state != EMPTY); latency from input transfer in EMPTY to outValid SHALL be exactly 1 cycle.
REQ-023 Transitions: push only -> +1; pop only -> -1; push and pop in ONE -> stays ONE with new entry behind; in FULL no push is possible.
REQ-024 Order SHALL be strictly FIFO; a stalled outReady=0 SHALL hold extenderOutput stable.
REQ-025 Mode 00: selected field zero-extended to DATA_WIDTH.
REQ-026 Mode 01: selected field sign-extended using its MSB.
REQ-027 Mode 10: sign-extended value shifted left SHIFT_AMOUNT, bits beyond DATA_WIDTH discarded, zero fill.
REQ-028 Mode 11: field placed at bits [DATA_WIDTH-1 : DATA_WIDTH-width], lower bits zero.
REQ-029 extenderSelection 11 SHALL store DATA_WIDTH'h1 regardless of mode.
REQ-030 Field widths SHALL each be < DATA_WIDTH; other settings are unsupported.

Reset
REQ-031 On reset assertion, immediately: state EMPTY, outValid 0, inReady 0, extenderOutput 0, buffer entries 0, errorFlag 0.
REQ-032 Reset mid-operation SHALL discard all buffered entries; inReady SHALL return to 1 on the first clock edge after reset deasserts.

Configuration
REQ-033 Macro EXTENDER_ERROR_EN defined: errorFlag set on any input transfer with extenderSelection 11, cleared only by reset.
REQ-034 Macro undefined: errorFlag tied 0, no flag logic; all other behaviour identical.

Verification
REQ-035 sel 00, mode 01, inputA 16'h8001 -> next cycle outValid=1, extenderOutput 32'hFFFF8001; mode 00 -> 32'h00008001.
REQ-036 sel 01, mode 10, inputB 21'h100000 -> 32'hFFC00000.
REQ-037 sel 10, mode 11, inputC 18'h3FFFF -> 32'hFFFFC000.
REQ-038 outReady=0, offer 3 requests (A=1,2,3, mode 00) -> inReady 0 after second accept; raise outReady -> outputs 1,2,3 in order, one per cycle, no loss or duplicate.
REQ-039 sel 11, mode 01 -> output 32'h00000001; errorFlag 1 with EXTENDER_ERROR_EN, 0 without; stays set until reset.
REQ-040 Reset asserted in FULL state -> outValid 0 and extenderOutput 0 without clock edge; after release, a new request emerges alone, 1 cycle later.

Source files
------------

// File: rtl/imm_extender_pipe.sv
// imm_extender_pipe: immediate extender feeding a 2-entry skid FIFO with valid/ready handshakes
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-high reset
//   inputA/inputB/inputC       immediate fields A (I-type), B (J-type), C (branch-type)
//   extenderSelection          field select: 00=A, 01=B, 10=C, 11=illegal (result is 1)
//   extenderMode               00 zero-ext, 01 sign-ext, 10 sign-ext then shift, 11 upper-place
//   inValid/inReady            request handshake
//   outValid/outReady          result handshake
//   extenderOutput             oldest buffered result
//   errorFlag                  sticky illegal-selection flag, present only with EXTENDER_ERROR_EN
module imm_extender_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int WIDTH_A      = 16,
    parameter int WIDTH_B      = 21,
    parameter int WIDTH_C      = 18,
    parameter int SHIFT_AMOUNT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH_A-1:0]    inputA,
    input  logic [WIDTH_B-1:0]    inputB,
    input  logic [WIDTH_C-1:0]    inputC,
    input  logic [1:0]            extenderSelection,
    input  logic [1:0]            extenderMode,
    input  logic                  inValid,
    output logic                  inReady,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] extenderOutput,
    output logic                  errorFlag
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state_q, state_d;
    logic rdy_q;
    logic push, pop;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [DATA_WIDTH-1:0] za, zb, zc, sa, sb, sc, ua, ub, uc, zx, sx, ux, res;
    assign za = {{(DATA_WIDTH-WIDTH_A){1'b0}}, inputA};
    assign zb = {{(DATA_WIDTH-WIDTH_B){1'b0}}, inputB};
    assign zc = {{(DATA_WIDTH-WIDTH_C){1'b0}}, inputC};
    assign sa = {{(DATA_WIDTH-WIDTH_A){inputA[WIDTH_A-1]}}, inputA};
    assign sb = {{(DATA_WIDTH-WIDTH_B){inputB[WIDTH_B-1]}}, inputB};
    assign sc = {{(DATA_WIDTH-WIDTH_C){inputC[WIDTH_C-1]}}, inputC};
    assign ua = {inputA, {(DATA_WIDTH-WIDTH_A){1'b0}}};
    assign ub = {inputB, {(DATA_WIDTH-WIDTH_B){1'b0}}};
    assign uc = {inputC, {(DATA_WIDTH-WIDTH_C){1'b0}}};
    assign zx = extenderSelection == 2'b00 ? za : extenderSelection == 2'b01 ? zb : zc;
    assign sx = extenderSelection == 2'b00 ? sa : extenderSelection == 2'b01 ? sb : sc;
    assign ux = extenderSelection == 2'b00 ? ua : extenderSelection == 2'b01 ? ub : uc;
    assign res = extenderSelection == 2'b11 ? DATA_WIDTH'(1) :
                 extenderMode == 2'b00 ? zx :
                 extenderMode == 2'b01 ? sx :
                 extenderMode == 2'b10 ? sx << SHIFT_AMOUNT : ux;
    // rdy_q holds inReady low through reset until the first edge after release
    assign inReady = rdy_q && state_q != FULL;
    assign outValid = state_q != EMPTY;
    assign extenderOutput = head_q;
    assign push = inValid && inReady;
    assign pop = outValid && outReady;
    always_comb begin
        state_d = push && !pop ? (state_q == EMPTY ? ONE : FULL) :
                  pop && !push ? (state_q == FULL ? ONE : EMPTY) : state_q;
        // head refills from tail when FULL drains, or takes the new word when it would be exposed
        head_d = pop && state_q == FULL ? tail_q :
                 push && (state_q == EMPTY || pop) ? res : head_q;
        tail_d = push && !pop && state_q == ONE ? res : tail_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            rdy_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q <= 1'b1;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
`ifdef EXTENDER_ERROR_EN
    logic err_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else if (push && extenderSelection == 2'b11) err_q <= 1'b1;
    end
    assign errorFlag = err_q;
`else
    assign errorFlag = 1'b0;
`endif
endmodule

// File: tb/tb_imm_extender_pipe.sv
// tb_imm_extender_pipe: table-driven, scoreboarded bench for imm_extender_pipe
module tb_imm_extender_pipe;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [15:0] inputA = '0;
    logic [20:0] inputB = '0;
    logic [17:0] inputC = '0;
    logic [1:0] extenderSelection = '0;
    logic [1:0] extenderMode = '0;
    logic inValid = 1'b0;
    logic outReady = 1'b0;
    logic inReady, outValid, errorFlag;
    logic [31:0] extenderOutput;
    logic [31:0] cur_exp = '0;
    logic [31:0] sb_q[$];
    int checks = 0;
    int errors = 0;
`ifdef EXTENDER_ERROR_EN
    logic exp_err = 1'b1;
`else
    logic exp_err = 1'b0;
`endif
    typedef struct {
        logic [1:0] s;
        logic [1:0] m;
        logic [15:0] a;
        logic [20:0] b;
        logic [17:0] c;
        logic [31:0] e;
    } vec_t;
    vec_t v[14];

    imm_extender_pipe dut (
        .clock(clock), .reset(reset), .inputA(inputA), .inputB(inputB), .inputC(inputC),
        .extenderSelection(extenderSelection), .extenderMode(extenderMode),
        .inValid(inValid), .inReady(inReady), .outValid(outValid), .outReady(outReady),
        .extenderOutput(extenderOutput), .errorFlag(errorFlag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) if (!reset) begin
        if (outValid && outReady) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected nothing", extenderOutput);
            end else chk("fifo_out", extenderOutput, sb_q.pop_front());
        end
        if (inValid && inReady) sb_q.push_back(cur_exp);
    end

    task automatic send(input logic [1:0] s, input logic [1:0] m, input logic [15:0] a,
                        input logic [20:0] b, input logic [17:0] c, input logic [31:0] e);
        bit ok = 0;
        extenderSelection = s;
        extenderMode = m;
        inputA = a;
        inputB = b;
        inputC = c;
        cur_exp = e;
        inValid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (inReady) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clock);
        #1 inValid = 1'b0;
    endtask

    task automatic drain();
        outReady = 1'b1;
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clock);
        #1 chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        v[0]  = '{2'd0, 2'd1, 16'h8001, 21'h0ABCD, 18'h01234, 32'hFFFF8001};
        v[1]  = '{2'd0, 2'd0, 16'h8001, 21'h1FFFF, 18'h3FFFF, 32'h00008001};
        v[2]  = '{2'd1, 2'd2, 16'hFFFF, 21'h100000, 18'h00001, 32'hFFC00000};
        v[3]  = '{2'd2, 2'd3, 16'h1111, 21'h00002, 18'h3FFFF, 32'hFFFFC000};
        v[4]  = '{2'd0, 2'd3, 16'h1234, 21'h1FFFF, 18'h3FFFF, 32'h12340000};
        v[5]  = '{2'd0, 2'd2, 16'h7FFF, 21'h1FFFF, 18'h3FFFF, 32'h0001FFFC};
        v[6]  = '{2'd1, 2'd0, 16'hFFFF, 21'h1FFFFF, 18'h3FFFF, 32'h001FFFFF};
        v[7]  = '{2'd1, 2'd1, 16'hFFFF, 21'h0FFFFF, 18'h3FFFF, 32'h000FFFFF};
        v[8]  = '{2'd1, 2'd3, 16'h0000, 21'h1ABCDE, 18'h00000, 32'hD5E6F000};
        v[9]  = '{2'd2, 2'd1, 16'hFFFF, 21'h1FFFFF, 18'h20000, 32'hFFFE0000};
        v[10] = '{2'd2, 2'd0, 16'hFFFF, 21'h1FFFFF, 18'h20000, 32'h00020000};
        v[11] = '{2'd2, 2'd2, 16'h0000, 21'h000000, 18'h2ABCD, 32'hFFFAAF34};
        v[12] = '{2'd3, 2'd1, 16'hFFFF, 21'h1FFFFF, 18'h3FFFF, 32'h00000001};
        v[13] = '{2'd3, 2'd0, 16'h0000, 21'h000000, 18'h00000, 32'h00000001};

        #1;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_inReady", 32'(inReady), 32'd0);
        chk("rst_output", extenderOutput, 32'd0);
        chk("rst_errorFlag", 32'(errorFlag), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1 chk("inReady_before_edge", 32'(inReady), 32'd0);
        @(posedge clock);
        #1 chk("inReady_after_edge", 32'(inReady), 32'd1);

        outReady = 1'b1;
        send(2'd0, 2'd1, 16'h8001, 21'h0, 18'h0, 32'hFFFF8001);
        chk("latency_outValid", 32'(outValid), 32'd1);
        chk("latency_output", extenderOutput, 32'hFFFF8001);
        @(posedge clock);
        #1 chk("single_pop_outValid", 32'(outValid), 32'd0);
        chk("err_before_illegal", 32'(errorFlag), 32'd0);

        foreach (v[i]) send(v[i].s, v[i].m, v[i].a, v[i].b, v[i].c, v[i].e);
        drain();
        chk("err_after_illegal", 32'(errorFlag), 32'(exp_err));
        send(2'd0, 2'd0, 16'h0042, 21'h0, 18'h0, 32'h00000042);
        drain();
        chk("err_sticky", 32'(errorFlag), 32'(exp_err));

        outReady = 1'b0;
        send(2'd0, 2'd0, 16'd1, 21'h0, 18'h0, 32'd1);
        send(2'd0, 2'd0, 16'd2, 21'h0, 18'h0, 32'd2);
        chk("full_inReady", 32'(inReady), 32'd0);
        repeat (3) @(posedge clock);
        #1 chk("stall_output", extenderOutput, 32'd1);
        chk("stall_outValid", 32'(outValid), 32'd1);
        fork
            send(2'd0, 2'd0, 16'd3, 21'h0, 18'h0, 32'd3);
            begin
                repeat (2) @(posedge clock);
                #1 outReady = 1'b1;
            end
        join
        drain();

        outReady = 1'b0;
        send(2'd1, 2'd0, 16'h0, 21'h00AA, 18'h0, 32'h000000AA);
        send(2'd1, 2'd0, 16'h0, 21'h00BB, 18'h0, 32'h000000BB);
        chk("full_before_reset", 32'(inReady), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outValid", 32'(outValid), 32'd0);
        chk("mid_rst_output", extenderOutput, 32'd0);
        chk("mid_rst_inReady", 32'(inReady), 32'd0);
        chk("mid_rst_errorFlag", 32'(errorFlag), 32'd0);
        sb_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 chk("post_rst_inReady", 32'(inReady), 32'd1);
        outReady = 1'b1;
        send(2'd2, 2'd0, 16'h0, 21'h0, 18'h00CC, 32'h000000CC);
        chk("post_rst_outValid", 32'(outValid), 32'd1);
        chk("post_rst_output", extenderOutput, 32'h000000CC);
        @(posedge clock);
        #1 chk("post_rst_alone", 32'(outValid), 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
